// File: rtl/vga_sprite_renderer.sv
// Programmable VGA raster timing with double-buffered, bitmap-masked sprite compositing.
// Pixel/sync outputs lag the stage-0 counter by 2 cycles; pending sprites latch only on the last cycle of a frame.
module vga_sprite_renderer #(
  parameter int H_VISIBLE  = 1600,
  parameter int H_FRONT    = 64,
  parameter int H_SYNC     = 192,
  parameter int H_BACK     = 304,
  parameter int V_VISIBLE  = 1200,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 46,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int SPRITES    = 4,
  parameter int SPRITE_DIM = 63,
  parameter int XW         = 12,
  parameter int YW         = 11
) (
  input  logic                                   clock_162,
  input  logic                                   rst,
  input  logic [SPRITE_DIM-1:0][SPRITE_DIM-1:0]  sprite,
  input  logic [SPRITES-1:0][YW-1:0]             sprite_row,
  input  logic [SPRITES-1:0][XW-1:0]             sprite_col,
  input  logic [SPRITES-1:0][11:0]               sprite_rgb,
  input  logic [SPRITES-1:0]                     sprite_en,
  input  logic [11:0]                            bg_rgb,
  input  logic                                   upd_valid,
  output logic                                   upd_ack,
  output logic                                   frame_start,
  output logic                                   vblank,
  output logic [3:0]                             RED,
  output logic [3:0]                             GREEN,
  output logic [3:0]                             BLUE,
  output logic                                   HSYNC,
  output logic                                   VSYNC
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int R       = (SPRITE_DIM - 1) / 2;
  localparam int IW      = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam int MN      = SPRITE_DIM * SPRITE_DIM;
  localparam logic signed [XW:0] RX = (XW+1)'(R);
  localparam logic signed [YW:0] RY = (YW+1)'(R);
  localparam logic [MN-1:0] MASK_ONE = {{(MN-1){1'b0}}, 1'b1};

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          h_last, frame_last;

  assign h_last      = (col == XW'(H_TOTAL - 1));
  assign frame_last  = h_last && (row == YW'(V_TOTAL - 1));
  assign frame_start = !rst && (col == '0) && (row == '0);
  assign vblank      = (row >= YW'(V_VISIBLE));

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (h_last) begin
      col <= '0;
      row <= (row == YW'(V_TOTAL - 1)) ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  logic [SPRITES-1:0][YW-1:0] sh_row;
  logic [SPRITES-1:0][XW-1:0] sh_col;
  logic [SPRITES-1:0][11:0]   sh_rgb;
  logic [SPRITES-1:0]         sh_en;

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      sh_row  <= '0;
      sh_col  <= '0;
      sh_rgb  <= '0;
      sh_en   <= '0;
      upd_ack <= 1'b0;
    end else begin
      upd_ack <= frame_last && upd_valid;
      if (frame_last && upd_valid) begin
        sh_row <= sprite_row;
        sh_col <= sprite_col;
        sh_rgb <= sprite_rgb;
        sh_en  <= sprite_en;
      end
    end
  end

  // Offsets are one bit wider than the coordinates so sprites near the edges clip instead of wrapping.
  logic [MN-1:0]          mask_flat;
  logic signed [XW:0]     dx;
  logic signed [YW:0]     dy;
  int                     pos;
  logic [SPRITES-1:0]     hit_vec;
  logic [IW-1:0]          win0;
  logic                   hit0, vis0, hs0, vs0;

  assign mask_flat = sprite;

  always_comb begin
    dx      = '0;
    dy      = '0;
    pos     = 0;
    hit_vec = '0;
    win0    = '0;
    hit0    = 1'b0;
    for (int i = 0; i < SPRITES; i++) begin
      dx  = $signed({1'b0, col}) - $signed({1'b0, sh_col[i]});
      dy  = $signed({1'b0, row}) - $signed({1'b0, sh_row[i]});
      pos = (int'(dy) + R) * SPRITE_DIM + (int'(dx) + R);
      hit_vec[i] = sh_en[i] && (dx >= -RX) && (dx <= RX) && (dy >= -RY) && (dy <= RY)
                   && |(mask_flat & (MASK_ONE << pos));
    end
    for (int i = SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win0 = IW'(i);
        hit0 = 1'b1;
      end
    end
  end

  assign vis0 = (col < XW'(H_VISIBLE)) && (row < YW'(V_VISIBLE));
  assign hs0  = (col >= XW'(H_VISIBLE + H_FRONT)) && (col < XW'(H_VISIBLE + H_FRONT + H_SYNC));
  assign vs0  = (row >= YW'(V_VISIBLE + V_FRONT)) && (row < YW'(V_VISIBLE + V_FRONT + V_SYNC));

  logic          s1_vld, s1_hit, s1_vis, s1_hs, s1_vs;
  logic [IW-1:0] s1_win;

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_vis <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_win <= '0;
      {RED, GREEN, BLUE} <= 12'h000;
      HSYNC  <= ~HS_POL;
      VSYNC  <= ~VS_POL;
    end else begin
      s1_vld <= 1'b1;
      s1_hit <= hit0;
      s1_vis <= vis0;
      s1_hs  <= hs0;
      s1_vs  <= vs0;
      s1_win <= win0;
      if (s1_vld && s1_vis) begin
        {RED, GREEN, BLUE} <= s1_hit ? sh_rgb[s1_win] : bg_rgb;
      end else begin
        {RED, GREEN, BLUE} <= 12'h000;
      end
      HSYNC <= (s1_vld && s1_hs) ? HS_POL : ~HS_POL;
      VSYNC <= (s1_vld && s1_vs) ? VS_POL : ~VS_POL;
    end
  end

endmodule
